// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dm_port_arbiter_pkg;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } arb_state_e;

    localparam logic [31:0] DMA_PC_TAG = 32'h0;

endpackage

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single data-memory port between the M stage and a DMA/debug
// requester; CPU wins by default, starvation forces a bounded DMA window.
module dm_port_arbiter
    import dm_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned MAX_BURST    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_mem_read,
    input  logic        cpu_mem_write,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [31:0] cpu_pc,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_last,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        dm_read,
    output logic        dm_write,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [31:0] dm_pc,
    input  logic [31:0] dm_rdata
);

    localparam int unsigned WAIT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BURST_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    arb_state_e         state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               cpu_acc;
    logic               cpu_grant;
    logic               dma_grant;

    assign cpu_acc = cpu_mem_read | cpu_mem_write;

    // State and counter registers plus the registered DMA read return.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_CPU;
            wait_q     <= '0;
            burst_q    <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            burst_q    <= burst_d;
            dma_rvalid <= dma_grant & ~dma_we;
            if (dma_grant && !dma_we) begin
                dma_rdata <= dm_rdata;
            end
        end
    end

    // Grant decision, starvation tracking and window exit.
    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        burst_d   = burst_q;
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        cpu_stall = 1'b0;
        if (!reset) begin
            if (state_q == S_CPU) begin
                if (cpu_acc) begin
                    cpu_grant = 1'b1;
                    if (dma_req) begin
                        wait_d = wait_q + WAIT_W'(1);
                        if ((32'(wait_q) + 32'd1) == STARVE_LIMIT) begin
                            state_d = S_DMA;
                        end
                    end else begin
                        wait_d = '0;
                    end
                end else begin
                    dma_grant = dma_req;
                    wait_d    = '0;
                end
            end else begin
                cpu_stall = cpu_acc;
                dma_grant = dma_req;
                if (dma_req) begin
                    burst_d = burst_q + BURST_W'(1);
                end
                // A dropped request ends the window just like dma_last does.
                if (!dma_req || dma_last || (32'(burst_q) == (MAX_BURST - 1))) begin
                    state_d = S_CPU;
                    burst_d = '0;
                    wait_d  = '0;
                end
            end
        end
    end

    // Memory port mux driven by whichever side holds the grant.
    always_comb begin
        dm_read   = 1'b0;
        dm_write  = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        dm_pc     = '0;
        cpu_rdata = '0;
        dma_ack   = dma_grant;
        if (cpu_grant) begin
            dm_write  = cpu_mem_write;
            dm_read   = cpu_mem_read & ~cpu_mem_write;
            dm_addr   = cpu_addr;
            dm_wdata  = cpu_wdata;
            dm_pc     = cpu_pc;
            cpu_rdata = dm_rdata;
        end else if (dma_grant) begin
            dm_write = dma_we;
            dm_read  = ~dma_we;
            dm_addr  = dma_addr;
            dm_wdata = dma_wdata;
            dm_pc    = DMA_PC_TAG;
        end
    end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Scoreboard bench for dm_port_arbiter: directed scenarios followed by
// randomized traffic against a per-cycle arbitration reference model.
module tb_dm_port_arbiter;

    localparam int unsigned LIMIT = 4;
    localparam int unsigned BURST = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_mem_read, cpu_mem_write;
    logic [31:0] cpu_addr, cpu_wdata, cpu_pc, cpu_rdata;
    logic        cpu_stall;
    logic        dma_req, dma_we, dma_last, dma_ack, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        dm_read, dm_write;
    logic [31:0] dm_addr, dm_wdata, dm_pc, dm_rdata;

    always #5 clk = ~clk;

    dm_port_arbiter #(.STARVE_LIMIT(LIMIT), .MAX_BURST(BURST)) dut (
        .clk(clk), .reset(reset),
        .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_pc(cpu_pc),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_last(dma_last), .dma_ack(dma_ack),
        .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_pc(dm_pc), .dm_rdata(dm_rdata)
    );

    // Environment data memory: combinational read, write at the clock edge.
    logic [31:0] mem [64];
    assign dm_rdata = mem[dm_addr[7:2]];
    always @(posedge clk) if (dm_write) mem[dm_addr[7:2]] <= dm_wdata;

    typedef struct {
        logic        stall, ack, rd, wr, rvalid;
        logic [31:0] addr, wdata, pc, crdata, rdata;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a priority mode and a forced-window mode.
    bit          m_window;
    int          m_denied;
    int          m_served;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic [31:0] ref_mem [64];
    bit          last_stall, last_dpend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic drive(input bit rst, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] pc, input bit dq,
                         input bit dw, input logic [31:0] da, input logic [31:0] dwd,
                         input bit dl);
        exp_t e;
        bit cpu_wins, dma_wins, acc, leave;
        @(posedge clk); #1;
        reset = rst; cpu_mem_read = rd; cpu_mem_write = wr; cpu_addr = a;
        cpu_wdata = wd; cpu_pc = pc; dma_req = dq; dma_we = dw; dma_addr = da;
        dma_wdata = dwd; dma_last = dl;

        acc = rd | wr;
        cpu_wins = 0; dma_wins = 0; leave = 0;
        e = '{stall: 0, ack: 0, rd: 0, wr: 0, rvalid: m_rvalid,
              addr: 0, wdata: 0, pc: 0, crdata: 0, rdata: m_rdata};
        if (!rst) begin
            if (!m_window) begin
                cpu_wins = acc;
                dma_wins = !acc && dq;
                m_denied = (acc && dq) ? m_denied + 1 : 0;
                if (m_denied == LIMIT) m_window = 1;
            end else begin
                e.stall  = acc;
                dma_wins = dq;
                if (dq) m_served++;
                leave = !dq || dl || (m_served == BURST);
            end
        end
        if (cpu_wins) begin
            e.wr = wr; e.rd = rd && !wr; e.addr = a; e.wdata = wd; e.pc = pc;
            e.crdata = ref_mem[a[7:2]];
            if (wr) ref_mem[a[7:2]] = wd;
        end else if (dma_wins) begin
            e.ack = 1; e.wr = dw; e.rd = !dw; e.addr = da; e.wdata = dwd; e.pc = 32'h0;
        end
        q.push_back(e);

        if (rst) begin
            m_window = 0; m_denied = 0; m_served = 0; m_rvalid = 0; m_rdata = 0;
        end else begin
            if (leave) begin
                m_window = 0; m_denied = 0; m_served = 0;
            end
            m_rvalid = dma_wins && !dw;
            if (dma_wins && !dw) m_rdata = ref_mem[da[7:2]];
            if (dma_wins && dw) ref_mem[da[7:2]] = dwd;
        end
        last_stall = e.stall;
        last_dpend = dq && !e.ack;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compares DUT outputs with the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
            chk("dma_ack", 32'(dma_ack), 32'(e.ack));
            chk("dm_read", 32'(dm_read), 32'(e.rd));
            chk("dm_write", 32'(dm_write), 32'(e.wr));
            chk("dm_addr", dm_addr, e.addr);
            chk("dm_wdata", dm_wdata, e.wdata);
            chk("dm_pc", dm_pc, e.pc);
            chk("cpu_rdata", cpu_rdata, e.crdata);
            chk("dma_rvalid", 32'(dma_rvalid), 32'(e.rvalid));
            chk("dma_rdata", dma_rdata, e.rdata);
            cyc++;
        end
    end

    bit          r_rd, r_wr, r_dq, r_dw, r_dl;
    logic [31:0] r_a, r_wd, r_pc, r_da, r_dwd;

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]     = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
            ref_mem[i] = (32'(i) * 32'h01010101) ^ 32'hA5A50000;
        end
        mem[4] = 32'hDEADBEEF; ref_mem[4] = 32'hDEADBEEF;
        m_window = 0; m_denied = 0; m_served = 0; m_rvalid = 0; m_rdata = 0;
        reset = 1; cpu_mem_read = 0; cpu_mem_write = 0; cpu_addr = 0; cpu_wdata = 0;
        cpu_pc = 0; dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0; dma_last = 0;
        // Reset values are unknown before the first edge; begin checking afterwards.
        @(posedge clk);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        drive(0, 1, 0, 32'h10, 0, 32'h100, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h1234, 1);
        drive(0, 0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 1);
        idle(); idle();

        // Continuous contention: starvation window of MAX_BURST accesses.
        repeat (14) drive(0, 1, 0, 32'h40, 0, 32'h200, 1, 1, 32'h80, 32'h55, 0);
        idle();

        // Window ended early by dma_last on its third access.
        for (int i = 0; i < 10; i++)
            drive(0, 1, 0, 32'h44, 0, 32'h204, 1, 0, 32'h84, 0, i == 6);
        idle();

        // Reset lands on the second window access, a write.
        for (int i = 0; i < 8; i++)
            drive(i == 5, 1, 0, 32'h48, 0, 32'h208, 1, 1, 32'h88, 32'hBAD0 + 32'(i), 0);
        idle();

        // Store arriving during a window is held and completes once.
        for (int i = 0; i < 14; i++)
            drive(0, i < 4, i >= 4 && i < 13, (i < 4) ? 32'h48 : 32'h4C, 32'hCAFE0000,
                  (i < 4) ? 32'h300 : 32'h304, i < 12, 0, 32'h8C, 0, 0);
        idle();

        for (int n = 0; n < 3000; n++) begin
            if (!last_stall) begin
                int op;
                op = int'($urandom % 4);
                r_rd = (op == 1); r_wr = (op == 2);
                r_a = {24'h0, 6'($urandom), 2'b00}; r_wd = $urandom; r_pc = $urandom;
            end
            if (!last_dpend) begin
                r_dq = ($urandom % 3) != 0; r_dw = $urandom % 2;
                r_da = {24'h0, 6'($urandom), 2'b00}; r_dwd = $urandom;
                r_dl = ($urandom % 5) == 0;
            end
            drive(($urandom % 150) == 0, r_rd, r_wr, r_a, r_wd, r_pc,
                  r_dq, r_dw, r_da, r_dwd, r_dl);
        end
        idle();
        @(posedge clk); @(posedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
